// File: rtl/move_pipe.sv
// Operand-move pipeline: MOV / XCHG / MOVZX / MOVSX with an optional
// repeat prefix that emits one beat per element, each carrying a signed byte offset.
module move_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [1:0]       size,
  input  logic [WIDTH-1:0] opnd0_r,
  input  logic [WIDTH-1:0] opnd1_r,
  input  logic             rep_en,
  input  logic [CNT_W-1:0] rep_count,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] opnd0_w,
  output logic [WIDTH-1:0] opnd1_w,
  output logic [WIDTH-1:0] out_offset,
  output logic             out_last,
  output logic [CNT_W-1:0] count_left,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshakes: a command is taken on a rising edge where in_valid && in_ready;
  // a beat is consumed on a rising edge where out_valid && out_ready. A presented
  // beat never changes until it is consumed.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_REP  = 2'd2;

  localparam logic [1:0] MODE_XCHG  = 2'b01;
  localparam logic [1:0] MODE_MOVZX = 2'b10;
  localparam logic [1:0] MODE_MOVSX = 2'b11;

  logic [1:0]       r_state;
  logic             r_valid;
  logic             r_last;
  logic             r_done;
  logic             r_dir;
  logic [WIDTH-1:0] r_opnd0_w;
  logic [WIDTH-1:0] r_opnd1_w;
  logic [WIDTH-1:0] r_offset;
  logic [WIDTH-1:0] r_step;
  logic [CNT_W-1:0] r_count_left;

  int               w_bits;
  logic [WIDTH-1:0] w_mask;
  logic             w_sign;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_res0;
  logic [WIDTH-1:0] w_res1;
  logic [WIDTH-1:0] w_step;

  // Source sizing: dword on a 32-bit datapath is simply the full width.
  always_comb begin
    w_bits = WIDTH;
    case (size)
      2'b00:   w_bits = 8;
      2'b01:   w_bits = 16;
      2'b10:   w_bits = 32;
      default: w_bits = WIDTH;
    endcase
    w_mask = '0;
    w_sign = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_mask[i] = (i < w_bits);
      if (i == w_bits - 1) w_sign = opnd1_r[i];
    end
    w_src = opnd1_r & w_mask;
    case (mode)
      MODE_MOVZX: w_res0 = w_src;
      MODE_MOVSX: w_res0 = w_sign ? (w_src | ~w_mask) : w_src;
      default:    w_res0 = w_src | (opnd0_r & ~w_mask);
    endcase
    w_res1 = (mode == MODE_XCHG) ? opnd0_r : opnd1_r;
    w_step = WIDTH'(w_bits / 8);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
      r_dir        <= 1'b0;
      r_opnd0_w    <= '0;
      r_opnd1_w    <= '0;
      r_offset     <= '0;
      r_step       <= '0;
      r_count_left <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (rep_en && (rep_count == '0)) begin
              // Empty repeat: completes immediately with no beat.
              r_done <= 1'b1;
            end else begin
              r_opnd0_w <= w_res0;
              r_opnd1_w <= w_res1;
              r_offset  <= '0;
              r_step    <= w_step;
              r_dir     <= dir;
              r_valid   <= 1'b1;
              if (rep_en) begin
                r_state      <= ST_REP;
                r_count_left <= rep_count - CNT_W'(1);
                r_last       <= (rep_count == CNT_W'(1));
              end else begin
                r_state      <= ST_HOLD;
                r_count_left <= '0;
                r_last       <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_REP: begin
          if (out_ready) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_offset     <= r_dir ? (r_offset - r_step) : (r_offset + r_step);
              r_count_left <= r_count_left - CNT_W'(1);
              r_last       <= (r_count_left == CNT_W'(1));
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_valid;
  assign out_last   = r_last;
  assign done       = r_done;
  assign opnd0_w    = r_opnd0_w;
  assign opnd1_w    = r_opnd1_w;
  assign out_offset = r_offset;
  assign count_left = r_count_left;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_move_pipe.sv
// Self-checking bench for move_pipe: directed scenarios plus randomized
// commands scored against a byte-level reference model.
module tb_move_pipe;

  localparam int W  = 32;
  localparam int CW = 32;
  localparam int BW = 4 * 32 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [1:0]    size;
  logic [W-1:0]  opnd0_r;
  logic [W-1:0]  opnd1_r;
  logic          rep_en;
  logic [CW-1:0] rep_count;
  logic          dir;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  opnd0_w;
  logic [W-1:0]  opnd1_w;
  logic [W-1:0]  out_offset;
  logic          out_last;
  logic [CW-1:0] count_left;
  logic          done;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  move_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .size(size), .opnd0_r(opnd0_r), .opnd1_r(opnd1_r),
    .rep_en(rep_en), .rep_count(rep_count), .dir(dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .opnd0_w(opnd0_w), .opnd1_w(opnd1_w), .out_offset(out_offset),
    .out_last(out_last), .count_left(count_left), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b11) ? W / 8 : ((1 << sz) > W / 8 ? W / 8 : (1 << sz));
  endfunction

  // Builds the destination value byte by byte from the instruction semantics.
  function automatic logic [W-1:0] model_d0(input logic [1:0] md, input logic [1:0] sz,
                                            input logic [W-1:0] o0, input logic [W-1:0] o1);
    logic [W-1:0] r;
    int nb;
    logic neg;
    nb  = nbytes(sz);
    neg = o1[8 * nb - 1];
    r   = '0;
    for (int b = 0; b < W / 8; b++) begin
      if (b < nb)              r[8*b +: 8] = o1[8*b +: 8];
      else if (md[1] == 1'b0)  r[8*b +: 8] = o0[8*b +: 8];
      else if (md == 2'b11)    r[8*b +: 8] = neg ? 8'hFF : 8'h00;
      else                     r[8*b +: 8] = 8'h00;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_d1(input logic [1:0] md,
                                            input logic [W-1:0] o0, input logic [W-1:0] o1);
    return (md == 2'b01) ? o0 : o1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic [1:0] md, input logic [1:0] sz, input logic [W-1:0] o0,
                           input logic [W-1:0] o1, input logic re, input int cnt, input logic d);
    mode = md; size = sz; opnd0_r = o0; opnd1_r = o1;
    rep_en = re; rep_count = CW'(cnt); dir = d;
    in_valid = 1'b1;
  endtask

  task automatic send_cmd(input logic [1:0] md, input logic [1:0] sz, input logic [W-1:0] o0,
                          input logic [W-1:0] o1, input logic re, input int cnt, input logic d);
    drive_cmd(md, sz, o0, o1, re, cnt, d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic scramble_inputs;
    mode = 2'($urandom_range(0, 3)); size = 2'($urandom_range(0, 3));
    opnd0_r = $urandom; opnd1_r = $urandom;
    rep_en = 1'($urandom_range(0, 1)); rep_count = CW'($urandom_range(0, 9));
    dir = 1'($urandom_range(0, 1));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    in_valid = 1'b1; out_ready = 1'b1;
    scramble_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({out_valid, out_last, done, count_left, out_offset, opnd0_w, opnd1_w} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%b cnt=%h off=%h d0=%h d1=%h, need all zero",
               out_valid, out_last, done, count_left, out_offset, opnd0_w, opnd1_w);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_movsx_byte;
    out_ready = 1'b1;
    send_cmd(2'b11, 2'b00, 32'h1234_5678, 32'h0000_0080, 1'b0, 0, 1'b0);
    checks++;
    if ({out_valid, opnd0_w, out_last, out_offset, count_left, done} !==
        {1'b1, 32'hFFFF_FF80, 1'b1, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL movsx_beat: got v=%b d0=%h l=%b off=%h cnt=%h done=%b, need 1 ffffff80 1 0 0 0",
               out_valid, opnd0_w, out_last, out_offset, count_left, done);
    end
    tick();
    checks++;
    if ({done, out_valid, in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL movsx_done: got done=%b v=%b rdy=%b, need 1 0 1", done, out_valid, in_ready);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL movsx_done_pulse: got done=%b, need 0", done);
    end
  endtask

  task automatic test_xchg_mov;
    out_ready = 1'b0;
    send_cmd(2'b01, 2'b11, 32'h1111_2222, 32'h3333_4444, 1'b0, 0, 1'b0);
    checks++;
    if ({opnd0_w, opnd1_w} !== {32'h3333_4444, 32'h1111_2222}) begin
      failures++;
      $display("FAIL xchg: got d0=%h d1=%h, need 33334444 11112222", opnd0_w, opnd1_w);
    end
    out_ready = 1'b1;
    tick();
    tick();
    send_cmd(2'b00, 2'b01, 32'hAAAA_BBBB, 32'h0000_CCCC, 1'b0, 0, 1'b0);
    checks++;
    if ({opnd0_w, opnd1_w} !== {32'hAAAA_CCCC, 32'h0000_CCCC}) begin
      failures++;
      $display("FAIL mov_word: got d0=%h d1=%h, need aaaacccc 0000cccc", opnd0_w, opnd1_w);
    end
    tick();
    tick();
    send_cmd(2'b10, 2'b01, 32'hFFFF_FFFF, 32'h1234_8765, 1'b0, 0, 1'b0);
    checks++;
    if (opnd0_w !== 32'h0000_8765) begin
      failures++;
      $display("FAIL movzx_word: got d0=%h, need 00008765", opnd0_w);
    end
    tick();
    tick();
  endtask

  task automatic test_rep_stall;
    logic [W-1:0] offs[3];
    logic [BW-1:0] held;
    offs[0] = 32'h0; offs[1] = 32'hFFFF_FFFC; offs[2] = 32'hFFFF_FFF8;
    out_ready = 1'b1;
    send_cmd(2'b00, 2'b10, 32'h0, 32'hDEAD_BEEF, 1'b1, 3, 1'b1);
    scramble_inputs();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid, out_offset, count_left, out_last, opnd0_w} !==
          {1'b1, offs[k], CW'(2 - k), (k == 2), 32'hDEAD_BEEF}) begin
        failures++;
        $display("FAIL rep_beat%0d: got v=%b off=%h cnt=%0d l=%b d0=%h, need 1 %h %0d %b deadbeef",
                 k, out_valid, out_offset, count_left, out_last, opnd0_w, offs[k], 2 - k, k == 2);
      end
      if (k == 1) begin
        held = {opnd0_w, opnd1_w, out_offset, count_left, out_last};
        out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          tick();
          checks++;
          if ({out_valid, opnd0_w, opnd1_w, out_offset, count_left, out_last} !== {1'b1, held}) begin
            failures++;
            $display("FAIL rep_stall%0d: got v=%b off=%h cnt=%0d, need held off=%h", s, out_valid,
                     out_offset, count_left, offs[1]);
          end
        end
        out_ready = 1'b1;
      end
      tick();
    end
    checks++;
    if ({done, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL rep_done: got done=%b v=%b, need 1 0", done, out_valid);
    end
  endtask

  task automatic test_rep_zero;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rep0_ready_before: got %b, need 1", in_ready);
    end
    send_cmd(2'b00, 2'b00, 32'h5, 32'h6, 1'b1, 0, 1'b0);
    checks++;
    if ({out_valid, done, in_ready} !== 3'b011) begin
      failures++;
      $display("FAIL rep0_n1: got v=%b done=%b rdy=%b, need 0 1 1", out_valid, done, in_ready);
    end
    tick();
    checks++;
    if ({out_valid, done, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL rep0_n2: got v=%b done=%b rdy=%b, need 0 0 1", out_valid, done, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    send_cmd(2'b00, 2'b00, 32'h0, 32'h77, 1'b1, 5, 1'b0);
    tick();
    checks++;
    if ({out_valid, count_left, out_offset} !== {1'b1, CW'(3), 32'h1}) begin
      failures++;
      $display("FAIL rstmid_beat2: got v=%b cnt=%0d off=%h, need 1 3 1", out_valid, count_left, out_offset);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, count_left, done, out_offset} !== '0) begin
      failures++;
      $display("FAIL rstmid_after: got v=%b cnt=%0d done=%b off=%h, need all 0",
               out_valid, count_left, done, out_offset);
    end
    tick();
    checks++;
    if ({done, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_nodone: got done=%b rdy=%b, need 0 1", done, in_ready);
    end
    send_cmd(2'b11, 2'b01, 32'h0, 32'h0000_8001, 1'b0, 0, 1'b0);
    checks++;
    if ({out_valid, opnd0_w, out_last} !== {1'b1, 32'hFFFF_8001, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_newcmd: got v=%b d0=%h l=%b, need 1 ffff8001 1", out_valid, opnd0_w, out_last);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [1:0] md, sz;
    logic [W-1:0] o0, o1;
    out_ready = 1'b1;
    md = 2'($urandom_range(0, 3)); sz = 2'($urandom_range(0, 3));
    o0 = $urandom; o1 = $urandom;
    drive_cmd(md, sz, o0, o1, 1'b0, 0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({out_valid, in_ready, opnd0_w, opnd1_w} !==
          {1'b1, 1'b0, model_d0(md, sz, o0, o1), model_d1(md, o0, o1)}) begin
        failures++;
        $display("FAIL b2b_beat%0d: got v=%b rdy=%b d0=%h d1=%h, need 1 0 %h %h", c, out_valid,
                 in_ready, opnd0_w, opnd1_w, model_d0(md, sz, o0, o1), model_d1(md, o0, o1));
      end
      md = 2'($urandom_range(0, 3)); sz = 2'($urandom_range(0, 3));
      o0 = $urandom; o1 = $urandom;
      drive_cmd(md, sz, o0, o1, 1'b0, 0, 1'b0);
      if (c == 7) in_valid = 1'b0;
      tick();
      checks++;
      if ({in_ready, done, out_valid} !== 3'b110) begin
        failures++;
        $display("FAIL b2b_gap%0d: got rdy=%b done=%b v=%b, need 1 1 0", c, in_ready, done, out_valid);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random;
    logic [1:0] md, sz;
    logic [W-1:0] o0, o1, d0, d1, off;
    logic re, d, v;
    logic [BW-1:0] got, tmp;
    int cnt, nb, budget;
    for (int c = 0; c < 40; c++) begin
      md = 2'($urandom_range(0, 3)); sz = 2'($urandom_range(0, 3));
      o0 = $urandom; o1 = $urandom;
      re = 1'($urandom_range(0, 1)); cnt = $urandom_range(0, 5); d = 1'($urandom_range(0, 1));
      nb = nbytes(sz);
      d0 = model_d0(md, sz, o0, o1);
      d1 = model_d1(md, o0, o1);
      if (!re) exp_q.push_back({d0, d1, 32'h0, 32'h0, 1'b1});
      else for (int k = 0; k < cnt; k++) begin
        off = d ? 32'(0 - k * nb) : 32'(k * nb);
        exp_q.push_back({d0, d1, off, 32'(cnt - 1 - k), k == cnt - 1});
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rand%0d_idle: got in_ready=%b, need 1", c, in_ready);
      end
      drive_cmd(md, sz, o0, o1, re, cnt, d);
      tick();
      scramble_inputs();
      in_valid = 1'($urandom_range(0, 1));
      if (re && cnt == 0) begin
        in_valid = 1'b0;
        checks++;
        if ({out_valid, done, in_ready} !== 3'b011) begin
          failures++;
          $display("FAIL rand%0d_zero: got v=%b done=%b rdy=%b, need 0 1 1", c, out_valid, done, in_ready);
        end
        continue;
      end
      budget = 0;
      while (exp_q.size() > 0 && budget < 100) begin
        got = {opnd0_w, opnd1_w, out_offset, count_left, out_last};
        checks++;
        if ({out_valid, done, got} !== {1'b1, 1'b0, exp_q[0]}) begin
          failures++;
          $display("FAIL rand%0d_beat: got v=%b done=%b beat=%h, need 1 0 %h", c, out_valid, done,
                   got, exp_q[0]);
        end
        out_ready = ($urandom_range(0, 2) != 0);
        v = out_valid;
        @(posedge clk);
        if (v && out_ready) tmp = exp_q.pop_front();
        #1;
        budget++;
        scramble_inputs();
        in_valid = (exp_q.size() == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL rand%0d_budget: got %0d beats left, need 0", c, exp_q.size());
        exp_q.delete();
        in_valid = 1'b0;
        do_reset();
      end else if ({done, out_valid, in_ready} !== 3'b101) begin
        failures++;
        $display("FAIL rand%0d_done: got done=%b v=%b rdy=%b, need 1 0 1", c, done, out_valid, in_ready);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = '0; size = '0; opnd0_r = '0; opnd1_r = '0;
    rep_en = 1'b0; rep_count = '0; dir = 1'b0;
    #2;
    test_reset();
    test_movsx_byte();
    test_xchg_mov();
    test_rep_stall();
    test_rep_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
